// File: rtl/pc_sequencer_pkg.sv
// Shared types for the program-counter sequencer.
package pc_sequencer_pkg;

    // Sequencer control states.
    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StHalt
    } seq_state_t;

    // Next-PC source selected by the control FSM.
    typedef enum logic [1:0] {
        SelHold,
        SelAdvance,
        SelBranch,
        SelReset
    } pc_sel_t;

    // Instructions are one 32-bit word; the PC steps in bytes.
    localparam int unsigned InstBytes = 4;

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch/decode-side signal bundle of the PC sequencer.
// master: the environment (control inputs, fetcher ready); slave: the sequencer.
interface pc_sequencer_if #(
    parameter int unsigned BIT_WIDTH = 32
) ();
    logic                 start;
    logic                 halt_req;
    logic                 stall;
    logic                 branch_valid;
    logic [BIT_WIDTH-1:0] branch_target;
    logic                 fetch_ready;
    logic                 fetch_enable;
    logic [BIT_WIDTH-1:0] pc;
    logic [BIT_WIDTH-1:0] inst_pc;
    logic                 inst_valid;
    logic                 running;
    logic                 halted;
    logic                 oor_fault;

    modport master (
        output start, halt_req, stall, branch_valid, branch_target, fetch_ready,
        input  fetch_enable, pc, inst_pc, inst_valid, running, halted, oor_fault
    );

    modport slave (
        input  start, halt_req, stall, branch_valid, branch_target, fetch_ready,
        output fetch_enable, pc, inst_pc, inst_valid, running, halted, oor_fault
    );
endinterface

// File: rtl/pc_sequencer_pc_next_sel.sv
// Combinational next-PC mux: hold / advance / branch / reset.
// Results are reduced modulo the code-memory span; oor flags an advance past the
// last word or a branch target beyond the span.
module pc_next_sel
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned BIT_WIDTH  = 32,
    parameter int unsigned INST_COUNT = 256,
    parameter int unsigned RESET_PC   = 0
) (
    input  pc_sel_t              sel,
    input  logic [BIT_WIDTH-1:0] pc,
    input  logic [BIT_WIDTH-1:0] target,
    output logic [BIT_WIDTH-1:0] pc_next,
    output logic                 oor
);
    localparam int unsigned SpanBytes = INST_COUNT * InstBytes;
    localparam logic [BIT_WIDTH-1:0] PcMask    = BIT_WIDTH'(SpanBytes - 1);
    localparam logic [BIT_WIDTH-1:0] LastPc    = BIT_WIDTH'(SpanBytes - InstBytes);
    localparam logic [BIT_WIDTH-1:0] AlignMask = ~BIT_WIDTH'(InstBytes - 1);
    localparam logic [BIT_WIDTH-1:0] Step      = BIT_WIDTH'(InstBytes);

    // Select the next PC and flag out-of-range moves.
    always_comb begin
        pc_next = pc;
        oor     = 1'b0;
        unique case (sel)
            SelHold: pc_next = pc;
            SelAdvance: begin
                pc_next = (pc + Step) & PcMask;
                oor     = (pc == LastPc);
            end
            SelBranch: begin
                // Misaligned low bits are dropped, out-of-span bits truncated.
                pc_next = target & PcMask & AlignMask;
                oor     = |(target & ~PcMask);
            end
            SelReset: pc_next = BIT_WIDTH'(RESET_PC) & PcMask;
            default: pc_next = pc;
        endcase
    end
endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: owns the PC, drives the fetcher, tags fetched words
// with their PC and a valid flag, and handles start/halt, stalls and branches.
// Optional feature macro: PC_HALT_ON_OOR_EN (halt with sticky fault on an
// out-of-range PC instead of wrapping/truncating).
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned BIT_WIDTH  = 32,
    parameter int unsigned INST_COUNT = 256,
    parameter int unsigned RESET_PC   = 0
) (
    input logic            clk,
    input logic            nreset,
    pc_sequencer_if.slave  bus
);
    seq_state_t           state_q, state_d, state_nxt;
    pc_sel_t              sel;
    logic [BIT_WIDTH-1:0] pc_q, pc_d, pc_next;
    logic [BIT_WIDTH-1:0] inst_pc_q, inst_pc_d;
    logic                 squash_q, squash_d;
    logic                 oor_q, oor_d;
    logic                 oor_hit;
    logic                 fetch_enable;

    assign fetch_enable = (state_q == StRun) & ~bus.halt_req;

    pc_next_sel #(
        .BIT_WIDTH  (BIT_WIDTH),
        .INST_COUNT (INST_COUNT),
        .RESET_PC   (RESET_PC)
    ) u_pc_next_sel (
        .sel     (sel),
        .pc      (pc_q),
        .target  (bus.branch_target),
        .pc_next (pc_next),
        .oor     (oor_hit)
    );

    // Control FSM: base next state, PC source and squash request.
    always_comb begin
        state_nxt = state_q;
        sel       = SelHold;
        squash_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.start && !bus.halt_req) begin
                    state_nxt = StRun;
                    sel       = SelReset;
                end
            end
            StRun: begin
                // A branch still loads the target even when halting this cycle.
                if (bus.branch_valid) begin
                    sel      = SelBranch;
                    squash_d = 1'b1;
                end else if (!bus.halt_req && !bus.stall) begin
                    sel = SelAdvance;
                end
                if (bus.halt_req) begin
                    state_nxt = StHalt;
                end
            end
            StHalt: begin
                if (bus.start && !bus.halt_req && !oor_q) begin
                    state_nxt = StRun;
                end
            end
            default: state_nxt = StIdle;
        endcase
    end

`ifdef PC_HALT_ON_OOR_EN
    // Out-of-range trap: halt, keep the last legal PC, latch the fault.
    always_comb begin
        state_d   = state_nxt;
        pc_d      = pc_next;
        oor_d     = oor_q;
        inst_pc_d = (fetch_enable && !bus.stall) ? pc_q : inst_pc_q;
        if (oor_hit) begin
            state_d = StHalt;
            pc_d    = pc_q;
            oor_d   = 1'b1;
        end
    end
`else
    logic unused_oor_hit;
    assign unused_oor_hit = oor_hit;

    // Wrapping build: the next PC is always taken and no fault is raised.
    always_comb begin
        state_d   = state_nxt;
        pc_d      = pc_next;
        oor_d     = 1'b0;
        inst_pc_d = (fetch_enable && !bus.stall) ? pc_q : inst_pc_q;
    end
`endif

    // State and datapath registers.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q   <= StIdle;
            pc_q      <= BIT_WIDTH'(RESET_PC);
            inst_pc_q <= '0;
            squash_q  <= 1'b0;
            oor_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_pc_q <= inst_pc_d;
            squash_q  <= squash_d;
            oor_q     <= oor_d;
        end
    end

    assign bus.fetch_enable = fetch_enable;
    assign bus.pc           = pc_q;
    assign bus.inst_pc      = inst_pc_q;
    assign bus.inst_valid   = bus.fetch_ready & ~squash_q;
    assign bus.running      = (state_q == StRun);
    assign bus.halted       = (state_q == StHalt);
    assign bus.oor_fault    = oor_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed scenarios followed by random
// stimulus, checked against a cycle-level behavioural model.
module tb_pc_sequencer;
    localparam int unsigned INST_COUNT = 32;
    localparam logic [31:0] SPAN       = INST_COUNT * 4;
    localparam logic [31:0] RESET_PC   = 32'h0;
`ifdef PC_HALT_ON_OOR_EN
    localparam bit OOR_EN = 1'b1;
`else
    localparam bit OOR_EN = 1'b0;
`endif
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    typedef struct {
        logic        fe;
        logic [31:0] pc;
        logic [31:0] inst_pc;
        logic        iv;
        logic        run;
        logic        hlt;
        logic        oor;
    } exp_t;

    logic clk;
    logic nreset;
    pc_sequencer_if #(.BIT_WIDTH(32)) bus ();

    pc_sequencer #(
        .BIT_WIDTH  (32),
        .INST_COUNT (INST_COUNT),
        .RESET_PC   (0)
    ) dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    bit          done  = 1'b0;
    logic        fe_prev = 1'b0;

    // Reference model state
    int          m_state;
    logic [31:0] m_pc;
    logic [31:0] m_inst_pc;
    bit          m_squash;
    bit          m_oor;

    task automatic model_reset();
        m_state   = M_IDLE;
        m_pc      = RESET_PC;
        m_inst_pc = 32'h0;
        m_squash  = 1'b0;
        m_oor     = 1'b0;
    endtask

    // One clock cycle: drive inputs, queue expected outputs, advance model.
    task automatic cycle(input bit rst_n, input bit s, input bit h, input bit st,
                         input bit bv, input logic [31:0] bt);
        exp_t        e;
        bit          fr;
        bit          fe;
        logic [31:0] tgt;
        logic [31:0] nxt_inst_pc;
        @(posedge clk);
        #1;
        fr = rst_n && fe_prev && ($urandom_range(0, 7) != 0);
        nreset            = rst_n;
        bus.start         = s;
        bus.halt_req      = h;
        bus.stall         = st;
        bus.branch_valid  = bv;
        bus.branch_target = bt;
        bus.fetch_ready   = fr;
        if (!rst_n) model_reset();
        fe = (m_state == M_RUN) && !h;
        e.fe      = fe;
        e.pc      = m_pc;
        e.inst_pc = m_inst_pc;
        e.iv      = fr && !m_squash;
        e.run     = (m_state == M_RUN);
        e.hlt     = (m_state == M_HALT);
        e.oor     = m_oor;
        sb.push_back(e);
        if (rst_n) begin
            nxt_inst_pc = (fe && !st) ? m_pc : m_inst_pc;
            m_squash    = (m_state == M_RUN) && bv;
            case (m_state)
                M_IDLE: if (s && !h) begin
                    m_state = M_RUN;
                    m_pc    = RESET_PC;
                end
                M_RUN: begin
                    if (bv) begin
                        tgt = bt & ~32'd3;
                        if (OOR_EN && tgt >= SPAN) begin
                            m_state = M_HALT;
                            m_oor   = 1'b1;
                        end else begin
                            m_pc = tgt % SPAN;
                        end
                    end else if (!h && !st) begin
                        if (m_pc + 4 >= SPAN) begin
                            if (OOR_EN) begin
                                m_state = M_HALT;
                                m_oor   = 1'b1;
                            end else begin
                                m_pc = 32'h0;
                            end
                        end else begin
                            m_pc = m_pc + 4;
                        end
                    end
                    if (h) m_state = M_HALT;
                end
                default: if (s && !h && !m_oor) m_state = M_RUN;
            endcase
            m_inst_pc = nxt_inst_pc;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, 0, 32'h0);
    endtask

    // Advance until the model's next-cycle pc (or inst_pc) equals want.
    task automatic run_until(input logic [31:0] want, input bit use_inst);
        for (int i = 0; i < 200; i++) begin
            if ((use_inst ? m_inst_pc : m_pc) == want) return;
            cycle(1, 0, 0, 0, 0, 32'h0);
        end
        total++;
        bad++;
        $display("FAIL run_until: never reached %h (model pc=%h)", want, m_pc);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Stimulus
    initial begin
        bit          r, s, h, st, bv;
        logic [31:0] bt;
        nreset = 1'b0;
        bus.start = 1'b0;
        bus.halt_req = 1'b0;
        bus.stall = 1'b0;
        bus.branch_valid = 1'b0;
        bus.branch_target = 32'h0;
        bus.fetch_ready = 1'b0;
        model_reset();

        cycle(0, 0, 0, 0, 0, 32'h0);
        cycle(0, 0, 0, 0, 0, 32'h0);
        idle(1);
        cycle(1, 1, 0, 0, 0, 32'h0);
        // Stall three cycles with inst_pc at 0x8
        run_until(32'h8, 1);
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 1, 0, 32'h0);
        // Misaligned branch from 0x10
        run_until(32'h10, 0);
        cycle(1, 0, 0, 0, 1, 32'h42);
        idle(3);
        // Back-to-back branches
        cycle(1, 0, 0, 0, 1, 32'h20);
        cycle(1, 0, 0, 0, 1, 32'h08);
        idle(2);
        // Halt at 0x14, then resume
        run_until(32'h14, 0);
        cycle(1, 0, 1, 0, 0, 32'h0);
        idle(3);
        cycle(1, 1, 0, 0, 0, 32'h0);
        idle(3);
        // Reset mid-run at 0x24, then restart
        run_until(32'h24, 0);
        cycle(0, 0, 0, 0, 0, 32'h0);
        idle(1);
        cycle(1, 1, 0, 0, 0, 32'h0);
        idle(2);
        // Last word: wrap or out-of-range halt, then an attempted restart
        run_until(SPAN - 4, 0);
        idle(2);
        cycle(1, 1, 0, 0, 0, 32'h0);
        idle(2);
        cycle(0, 0, 0, 0, 0, 32'h0);
        cycle(1, 1, 0, 0, 0, 32'h0);
        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 99) != 0);
            s  = ($urandom_range(0, 7) == 0);
            h  = ($urandom_range(0, 15) == 0);
            st = ($urandom_range(0, 5) == 0);
            bv = ($urandom_range(0, 7) == 0);
            bt = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 255);
            cycle(r, s, h, st, bv, bt);
        end
        done = 1'b1;
    end

    // Monitor: compare DUT outputs against the queued expectations each cycle.
    initial begin
        exp_t e;
        while (!(done && sb.size() == 0)) begin
            @(negedge clk);
            fe_prev = bus.fetch_enable;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("fetch_enable", 32'(bus.fetch_enable), 32'(e.fe));
                check("pc", bus.pc, e.pc);
                check("inst_pc", bus.inst_pc, e.inst_pc);
                check("inst_valid", 32'(bus.inst_valid), 32'(e.iv));
                check("running", 32'(bus.running), 32'(e.run));
                check("halted", 32'(bus.halted), 32'(e.hlt));
                check("oor_fault", 32'(bus.oor_fault), 32'(e.oor));
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Guard against a stuck run.
    initial begin
        #400000;
        $display("FAIL watchdog: bench did not complete (total=%0d bad=%0d)", total, bad);
        $fatal(1, "watchdog expired");
    end
endmodule
